// File: rtl/cos_th2_engine.sv
// Two-link inverse-kinematics helper: cos_th2 = (x^2+y^2-l1^2-l2^2)/(2*l1*l2), signed Q2.FRAC_W.
// Latency: fixed, done pulses FRAC_W+9 cycles after the accepting edge (MUL 5, PREP 1, DIV FRAC_W+2, FIN 1).
// Backpressure: ready is high only in IDLE; start while busy is dropped, nothing is queued.
module cos_th2_engine #(
  parameter int COORD_W = 14,
  parameter int LEN_W   = 16,
  parameter int FRAC_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COORD_W-1:0]    x_target,
  input  logic [COORD_W-1:0]    y_target,
  input  logic [LEN_W-1:0]      l1,
  input  logic [LEN_W-1:0]      l2,
  output logic                  ready,
  output logic                  done,
  output logic [FRAC_W+1:0]     cos_th2,
  output logic [1:0]            status
);

  localparam int RES_W = FRAC_W + 2;
  localparam int OW    = (COORD_W > LEN_W) ? COORD_W : LEN_W;  // multiplier operand width
  localparam int PW    = 2 * OW;                               // product width
  localparam int NW    = PW + 2;                               // numerator / denominator width
  localparam int QW    = FRAC_W + 2;                           // quotient bits produced
  localparam int CW    = $clog2(QW + 1);                       // step counter width

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_PREP, S_DIV, S_FIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;

  // Operands captured at acceptance
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [LEN_W-1:0]    r_l1;
  logic [LEN_W-1:0]    r_l2;

  // Products from the shared multiplier
  logic [PW-1:0]       r_xx;
  logic [PW-1:0]       r_yy;
  logic [PW-1:0]       r_l1s;
  logic [PW-1:0]       r_l2s;
  logic [PW-1:0]       r_l12;

  // Divider state
  logic                r_neg;
  logic                r_sat;
  logic                r_degen;
  logic [NW-1:0]       r_den;
  logic [NW-1:0]       r_rem;
  logic [1:0]          r_lo;
  logic [QW-1:0]       r_q;

  // Held results
  logic [RES_W-1:0]    r_cos;
  logic [1:0]          r_status;

  // Combinational datapath
  logic [COORD_W-1:0]  w_ax;
  logic [COORD_W-1:0]  w_ay;
  logic [OW-1:0]       w_ma;
  logic [OW-1:0]       w_mb;
  logic [PW-1:0]       w_prod;
  logic [NW-1:0]       w_n;
  logic [NW-1:0]       w_absn;
  logic [NW-1:0]       w_d;
  logic [NW:0]         w_trial;
  logic [NW:0]         w_diff;
  logic                w_qbit;
  logic [NW-1:0]       w_rem_nxt;
  logic [RES_W-1:0]    w_one;
  logic [RES_W-1:0]    w_mag;
  logic [RES_W-1:0]    w_res;
  logic [1:0]          w_st;

  // Coordinates are squared as magnitudes so one unsigned multiplier serves all five products.
  assign w_ax   = r_x[COORD_W-1] ? (~r_x + COORD_W'(1)) : r_x;
  assign w_ay   = r_y[COORD_W-1] ? (~r_y + COORD_W'(1)) : r_y;

  // Select multiplier operands by MUL step: x^2, y^2, l1^2, l2^2, l1*l2.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_cnt)
      CW'(0): begin w_ma = OW'(w_ax); w_mb = OW'(w_ax); end
      CW'(1): begin w_ma = OW'(w_ay); w_mb = OW'(w_ay); end
      CW'(2): begin w_ma = OW'(r_l1); w_mb = OW'(r_l1); end
      CW'(3): begin w_ma = OW'(r_l2); w_mb = OW'(r_l2); end
      CW'(4): begin w_ma = OW'(r_l1); w_mb = OW'(r_l2); end
      default: begin w_ma = '0; w_mb = '0; end
    endcase
  end

  assign w_prod = PW'(w_ma) * PW'(w_mb);

  // N is two's complement in NW bits; the two guard bits cover the full sum range.
  assign w_n    = {2'b00, r_xx} + {2'b00, r_yy} - {2'b00, r_l1s} - {2'b00, r_l2s};
  assign w_absn = w_n[NW-1] ? (~w_n + NW'(1)) : w_n;
  assign w_d    = {1'b0, r_l12, 1'b0};

  // Restoring step: the remainder starts at |N|>>2 and the two dropped bits are shifted back
  // in first, so the first two quotient bits carry weights 2 and 1. With |N|<=D the remainder
  // always stays below D, keeping the trial value inside NW+1 bits.
  assign w_trial   = {r_rem, r_lo[1]};
  assign w_diff    = w_trial - {1'b0, r_den};
  assign w_qbit    = (w_trial >= {1'b0, r_den});
  assign w_rem_nxt = w_qbit ? w_diff[NW-1:0] : w_trial[NW-1:0];

  // Final result: degenerate beats saturation; magnitude truncated before sign is applied.
  assign w_one = RES_W'(1) << FRAC_W;
  assign w_mag = r_sat ? w_one : r_q;
  assign w_res = r_degen ? '0 : (r_neg ? (~w_mag + RES_W'(1)) : w_mag);
  assign w_st  = r_degen ? 2'b10 : (r_sat ? 2'b01 : 2'b00);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state sequencing through the fixed-length phases.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_MUL;
      S_MUL:  if (r_cnt == CW'(4)) w_next = S_PREP;
      S_PREP: w_next = S_DIV;
      S_DIV:  if (r_cnt == CW'(QW - 1)) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands, collect products, prepare and run the divider, hold the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_l1     <= '0;
      r_l2     <= '0;
      r_xx     <= '0;
      r_yy     <= '0;
      r_l1s    <= '0;
      r_l2s    <= '0;
      r_l12    <= '0;
      r_neg    <= 1'b0;
      r_sat    <= 1'b0;
      r_degen  <= 1'b0;
      r_den    <= '0;
      r_rem    <= '0;
      r_lo     <= '0;
      r_q      <= '0;
      r_cos    <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x   <= x_target;
            r_y   <= y_target;
            r_l1  <= l1;
            r_l2  <= l2;
            r_cnt <= '0;
          end
        end
        S_MUL: begin
          case (r_cnt)
            CW'(0):  r_xx  <= w_prod;
            CW'(1):  r_yy  <= w_prod;
            CW'(2):  r_l1s <= w_prod;
            CW'(3):  r_l2s <= w_prod;
            default: r_l12 <= w_prod;
          endcase
          r_cnt <= (r_cnt == CW'(4)) ? '0 : r_cnt + CW'(1);
        end
        S_PREP: begin
          r_neg   <= w_n[NW-1];
          r_degen <= (w_d == '0);
          r_sat   <= (w_absn > w_d);
          r_den   <= w_d;
          r_rem   <= w_absn >> 2;
          r_lo    <= w_absn[1:0];
          r_q     <= '0;
          r_cnt   <= '0;
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[QW-2:0], w_qbit};
          r_lo  <= {r_lo[0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIN: begin
          r_cos    <= w_res;
          r_status <= w_st;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // The new result is presented alongside the done pulse and held afterwards.
  assign ready   = (r_state == S_IDLE);
  assign done    = (r_state == S_FIN);
  assign cos_th2 = done ? w_res : r_cos;
  assign status  = done ? w_st  : r_status;

endmodule

// File: tb/tb_cos_th2_engine.sv
// Directed bench for cos_th2_engine: vector table plus hand-written multi-cycle sequences.
// Inputs are driven and outputs sampled on the falling edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_cos_th2_engine;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [13:0] x_target;
  logic signed [13:0] y_target;
  logic [15:0]        l1;
  logic [15:0]        l2;
  logic               ready;
  logic               done;
  logic [17:0]        cos_th2;
  logic [1:0]         status;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic signed [13:0] x;
    logic signed [13:0] y;
    logic [15:0]        a;
    logic [15:0]        b;
    logic [17:0]        cos;
    logic [1:0]         st;
    bit                 chg;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  cos_th2_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x_target (x_target),
    .y_target (y_target),
    .l1       (l1),
    .l2       (l2),
    .ready    (ready),
    .done     (done),
    .cos_th2  (cos_th2),
    .status   (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    lat = 0;
    @(negedge clk);
    chk($sformatf("v%0d_ready_before", idx), {31'd0, ready}, 32'd1);
    x_target = v.x; y_target = v.y; l1 = v.a; l2 = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.chg) begin
      x_target = 14'sd300; y_target = -14'sd77; l1 = 16'd3; l2 = 16'd0;
    end
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d_latency", idx), lat, 32'd25);
    chk($sformatf("v%0d_cos", idx), {14'd0, cos_th2}, {14'd0, v.cos});
    chk($sformatf("v%0d_status", idx), {30'd0, status}, {30'd0, v.st});
    @(negedge clk);
    chk($sformatf("v%0d_done_one_cycle", idx), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_ready_after", idx), {31'd0, ready}, 32'd1);
    chk($sformatf("v%0d_cos_held", idx), {14'd0, cos_th2}, {14'd0, v.cos});
  endtask

  initial begin
    int dones;
    int d1;
    int d2;

    vt[0]  = '{14'sd200,   14'sd0,   16'd100,  16'd100,  18'h10000, 2'd0, 1'b0};
    vt[1]  = '{-14'sd200,  14'sd0,   16'd100,  16'd100,  18'h10000, 2'd0, 1'b0};
    vt[2]  = '{14'sd100,   14'sd0,   16'd100,  16'd100,  18'h38000, 2'd0, 1'b0};
    vt[3]  = '{14'sd100,   14'sd100, 16'd100,  16'd100,  18'h00000, 2'd0, 1'b0};
    vt[4]  = '{14'sd0,     14'sd0,   16'd100,  16'd100,  18'h30000, 2'd0, 1'b0};
    vt[5]  = '{14'sd300,   14'sd0,   16'd100,  16'd100,  18'h10000, 2'd1, 1'b0};
    vt[6]  = '{14'sd0,     14'sd0,   16'd300,  16'd100,  18'h30000, 2'd1, 1'b0};
    vt[7]  = '{14'sd50,    14'sd50,  16'd100,  16'd0,    18'h00000, 2'd2, 1'b0};
    vt[8]  = '{14'sd0,     14'sd0,   16'd0,    16'd0,    18'h00000, 2'd2, 1'b0};
    vt[9]  = '{14'sd1,     14'sd0,   16'd100,  16'd100,  18'h30004, 2'd0, 1'b0};
    vt[10] = '{14'sd123,   14'sd0,   16'd100,  16'd100,  18'h3C1A7, 2'd0, 1'b0};
    vt[11] = '{14'sd170,   14'sd0,   16'd100,  16'd100,  18'h071EB, 2'd0, 1'b0};
    vt[12] = '{14'sd0,     14'sd200, 16'd100,  16'd100,  18'h10000, 2'd0, 1'b0};
    vt[13] = '{14'sd100,   14'sd0,   16'd100,  16'd100,  18'h38000, 2'd0, 1'b1};
    vt[14] = '{-14'sd8192, 14'sd0,   16'd4096, 16'd4096, 18'h10000, 2'd0, 1'b0};
    vt[15] = '{14'sd201,   14'sd0,   16'd100,  16'd100,  18'h10000, 2'd1, 1'b0};
    vt[16] = '{14'sd199,   14'sd0,   16'd100,  16'd100,  18'h0FAE4, 2'd0, 1'b0};

    reset = 1'b0; start = 1'b0;
    x_target = '0; y_target = '0; l1 = '0; l2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'd0, ready},   32'd1);
    chk("rst_done",   {31'd0, done},    32'd0);
    chk("rst_cos",    {14'd0, cos_th2}, 32'd0);
    chk("rst_status", {30'd0, status},  32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vt[i], i);

    // Start held through cycles 1..24 of a busy computation must be ignored.
    @(negedge clk);
    x_target = 14'sd100; y_target = 14'sd0; l1 = 16'd100; l2 = 16'd100; start = 1'b1;
    @(negedge clk);
    x_target = 14'sd300;
    dones = 0; d1 = 0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        dones++;
        if (d1 == 0) begin
          d1 = c;
          chk("busy_start_cos", {14'd0, cos_th2}, 32'h38000);
        end
      end
      if (c == 24) start = 1'b0;
      @(negedge clk);
    end
    chk("busy_start_done_count", dones, 32'd1);
    chk("busy_start_latency", d1, 32'd25);

    // Start held continuously gives results every 26 cycles.
    x_target = 14'sd300; y_target = 14'sd0; l1 = 16'd100; l2 = 16'd100; start = 1'b1;
    @(negedge clk);
    dones = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin
        dones++;
        if (d1 == 0) d1 = c;
        else if (d2 == 0) begin
          d2 = c;
          start = 1'b0;
          chk("b2b_cos", {14'd0, cos_th2}, 32'h10000);
          chk("b2b_status", {30'd0, status}, 32'd1);
        end
      end
      if (c == 60) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b_first", d1, 32'd25);
    chk("b2b_second", d2, 32'd51);
    chk("b2b_done_count", dones, 32'd2);

    // Reset at cycle 10 aborts the computation and clears the held result.
    @(negedge clk);
    chk("abort_prev_status", {30'd0, status}, 32'd1);
    x_target = 14'sd100; y_target = 14'sd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready",  {31'd0, ready},   32'd1);
    chk("abort_done",   {31'd0, done},    32'd0);
    chk("abort_cos",    {14'd0, cos_th2}, 32'd0);
    chk("abort_status", {30'd0, status},  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    chk("abort_ready_after", {31'd0, ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cos_th2_engine.md
COS_TH2_ENGINE -- requirements
Module: cos_th2_engine

Interface
REQ-001 Parameter COORD_W, default 14: width of the signed two's-complement target coordinates.
REQ-002 Parameter LEN_W, default 16: width of the unsigned link lengths, in the same units as the coordinates.
REQ-003 Parameter FRAC_W, default 16: number of fraction bits in the result; result width RES_W = FRAC_W+2.
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port start  in  1  request a computation; sampled only while ready=1.
REQ-007 Port x_target  in  COORD_W  signed target X.
REQ-008 Port y_target  in  COORD_W  signed target Y.
REQ-009 Port l1  in  LEN_W  unsigned link 1 length.
REQ-010 Port l2  in  LEN_W  unsigned link 2 length.
REQ-011 Port ready  out  1  high while the engine is idle and can accept start.
REQ-012 Port done  out  1  one-cycle pulse when cos_th2 and status are updated.
REQ-013 Port cos_th2  out  RES_W  signed Q2.FRAC_W result, (x²+y²−l1²−l2²)/(2·l1·l2).
REQ-014 Port status  out  2  result status: 00 ok, 01 out of reach (saturated), 10 degenerate (l1 or l2 zero).

Function
REQ-015 A start is accepted on a rising edge where start=1 and ready=1; x_target, y_target, l1 and l2 are registered on that edge, and later input changes have no effect.
REQ-016 start while ready=0 is ignored, with no queuing.
REQ-017 FSM states are IDLE, MUL, PREP, DIV and FIN; ready=1 only in IDLE.
REQ-018 MUL lasts 5 cycles with a step counter of 0..4 and uses one shared multiplier to form x², y², l1², l2² and l1·l2 in that order.
REQ-019 PREP lasts 1 cycle and forms N = x²+y²−l1²−l2² (signed, width max(2·COORD_W,2·LEN_W)+2), D = 2·l1·l2, sign(N) and |N|.
REQ-020 DIV runs a restoring divide of |N|·2^FRAC_W by D, one quotient bit per cycle, for exactly FRAC_W+2 cycles.
REQ-021 FIN lasts 1 cycle: it applies the sign, loads cos_th2 and status, pulses done and returns to IDLE.
REQ-022 Latency is fixed: done is high in the FRAC_W+9th cycle after the acceptance edge (25 cycles at defaults), independent of operand values.
REQ-023 ready returns to 1 in the cycle after done, so a new start may be accepted on the edge that follows the done cycle.
REQ-024 The quotient magnitude is truncated toward zero before the sign is applied, so a negative result is −trunc(|N|/D).
REQ-025 If D=0, the result is cos_th2=0 with status=10, and this overrides all other checks.
REQ-026 If |N|>D, the result is cos_th2=+1.0 (2^FRAC_W) or −1.0 by sign(N), with status=01.
REQ-027 |N|=D is in reach and gives ±1.0 with status=00.
REQ-028 Degenerate and out-of-reach cases still take the full fixed latency.
REQ-029 cos_th2 and status hold their last values until the next FIN.

Reset
REQ-030 While reset=0, the FSM is forced to IDLE and all internal registers clear.
REQ-031 Reset values: ready=1, done=0, cos_th2=0, status=00.
REQ-032 Reset asserted mid-computation aborts it; no done is issued for that request after reset is released.
REQ-033 The first start is accepted on the first rising edge at which reset=1 and start=1.

Verification (defaults; l1=l2=100 unless stated)
REQ-034 x=200, y=0 -> after 25 cycles done=1, cos_th2=0x10000 (+1.0), status=00; x=−200 gives the same result.
REQ-035 x=100, y=0 -> cos_th2=0x38000 (−0.5), status=00; x=100, y=100 -> cos_th2=0, status=00; x=0, y=0 -> cos_th2=0x30000 (−1.0), status=00.
REQ-036 x=300, y=0 -> cos_th2=0x10000, status=01; l2=0 with any target -> cos_th2=0, status=10, still 25-cycle latency.
REQ-037 A second start pulsed at cycles 1..24 after acceptance -> ignored and exactly one done is produced; a start held high continuously -> back-to-back results every 26 cycles.
REQ-038 Inputs changed on the cycle after acceptance -> the result matches the operands sampled at acceptance.
REQ-039 reset=0 at cycle 10 of a computation -> ready=1, cos_th2=0, and no done pulse within 40 cycles after release without a new start.
